// File: rtl/mem_copy_engine.sv
// Bus master for the single-port data memory: block copy (memmove-safe on overlap) or block
// fill, started by a one-cycle command, reporting done / err / words_done.
module mem_copy_engine #(
    parameter int unsigned DEPTH = 4000,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_value,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);
    typedef enum logic [2:0] {StIdle, StRd, StWr, StFill, StFin} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic [31:0]      fill_q, fill_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      buf_q, buf_d;
    logic             desc_q, desc_d;
    logic             err_q, err_d;

    logic [32:0]      src_end, dst_end;
    logic [31:0]      len_m1, src_step, dst_step;
    logic [LEN_W:0]   words_inc;
    logic             range_err, last_word, go_desc;

    // 33-bit sums so a base near 2^32 cannot wrap past the check
    assign src_end   = {1'b0, src_addr} + 33'(len);
    assign dst_end   = {1'b0, dst_addr} + 33'(len);
    assign range_err = (dst_end > 33'(DEPTH)) || (!mode && (src_end > 33'(DEPTH)));
    assign go_desc   = dst_addr > src_addr;
    assign len_m1    = 32'(len) - 32'd1;

    assign words_inc = {1'b0, words_q} + {{LEN_W{1'b0}}, 1'b1};
    assign last_word = (words_inc == {1'b0, len_q});
    assign src_step  = desc_q ? src_q - 32'd1 : src_q + 32'd1;
    assign dst_step  = desc_q ? dst_q - 32'd1 : dst_q + 32'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        fill_d  = fill_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        desc_d  = desc_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = len;
                    fill_d  = fill_value;
                    words_d = '0;
                    err_d   = range_err;
                    desc_d  = !mode && go_desc;
                    if (!mode && go_desc) begin
                        src_d = src_addr + len_m1;
                        dst_d = dst_addr + len_m1;
                    end else begin
                        src_d = src_addr;
                        dst_d = dst_addr;
                    end
                    if (range_err || (len == '0)) begin
                        state_d = StFin;
                    end else begin
                        state_d = mode ? StFill : StRd;
                    end
                end
            end
            StRd: begin
                buf_d = mem_rd;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    state_d = StWr;
                end
            end
            StWr, StFill: begin
                // The write driven this cycle commits even when abort is sampled.
                words_d = words_inc[LEN_W-1:0];
                src_d   = src_step;
                dst_d   = dst_step;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else if (last_word) begin
                    state_d = StFin;
                end else if (state_q == StWr) begin
                    state_d = StRd;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            words_q <= '0;
            fill_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            desc_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            fill_q  <= fill_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            desc_q  <= desc_d;
            err_q   <= err_d;
        end
    end

    // Decoded from the state register, so async reset clears them immediately.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        unique case (state_q)
            StRd: begin
                busy     = 1'b1;
                mem_addr = src_q;
            end
            StWr: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dst_q;
                mem_wd   = buf_q;
            end
            StFill: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dst_q;
                mem_wd   = fill_q;
            end
            StFin:   done = 1'b1;
            default: ;
        endcase
    end

    assign err        = err_q;
    assign words_done = words_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine: a command-level memmove/fill model predicts every
// cycle of bus activity and the final memory image.
module tb_mem_copy_engine;
    localparam int unsigned DEPTH = 4000;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [31:0]      fill_value = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, err, mem_we;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      mem_addr, mem_wd, mem_rd;

    mem_copy_engine #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .fill_value(fill_value), .abort(abort), .busy(busy),
        .done(done), .err(err), .words_done(words_done), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    logic [31:0] exp_mem [DEPTH];

    assign mem_rd = (mem_addr < DEPTH) ? mem[mem_addr[11:0]] : 32'h0;
    always @(posedge clk) if (mem_we && mem_addr < DEPTH) mem[mem_addr[11:0]] <= mem_wd;

    typedef struct {
        logic        busy, done, we, err;
        logic [31:0] addr, wd;
        int          words;
    } exp_t;

    exp_t q[$];
    logic idle_err = 1'b0;
    int   idle_words = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   first_we = -1;
    int   done_lat = 0;

    function automatic exp_t mk(logic b, logic d, logic w, logic e, int a, logic [31:0] v, int n);
        exp_t x;
        x.busy = b; x.done = d; x.we = w; x.err = e; x.addr = 32'(a); x.wd = v; x.words = n;
        return x;
    endfunction

    // Per-cycle compare against the predicted trace (idle expectations when the trace is empty).
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) e = mk(0, 0, 0, 0, 0, 0, 0);
        else if (q.size() > 0) e = q.pop_front();
        else e = mk(0, 0, 0, idle_err, 0, 0, idle_words);
        if (rst_n && mem_we === 1'b1 && first_we < 0) first_we = int'(mem_addr);
        n_cmp++;
        if (busy !== e.busy || done !== e.done || mem_we !== e.we || err !== e.err ||
            mem_addr !== e.addr || mem_wd !== e.wd || words_done !== LEN_W'(e.words)) begin
            n_bad++;
            $display("FAIL outputs t=%0t got busy=%b done=%b we=%b err=%b addr=%0h wd=%h words=%0d want busy=%b done=%b we=%b err=%b addr=%0h wd=%h words=%0d",
                     $time, busy, done, mem_we, err, mem_addr, mem_wd, words_done,
                     e.busy, e.done, e.we, e.err, e.addr, e.wd, e.words);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_mem(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s %0d words differ, first at %0d got %h want %h", name, bad, first,
                     mem[first], exp_mem[first]);
        end
    endtask

    // Issue one command from an IDLE cycle; abort_c / rst_c are 1-based cycles after acceptance.
    task automatic run_cmd(input logic m, input int s, input int d, input int n,
                           input logic [31:0] f, input int abort_c, input int rst_c,
                           input bit spur);
        exp_t        act[$];
        logic [31:0] vals[$];
        bit          fail, desc, aborted;
        int          words, total, idx;
        logic        fin_err;

        fail = (longint'(d) + n > DEPTH) || (!m && longint'(s) + n > DEPTH);
        q.push_back(mk(0, 0, 0, idle_err, 0, 0, idle_words));
        if (!fail && n > 0) begin
            if (!m) begin
                desc = d > s;
                for (int i = 0; i < n; i++) begin
                    idx = desc ? n - 1 - i : i;
                    vals.push_back(exp_mem[s + idx]);
                end
                for (int i = 0; i < n; i++) begin
                    idx = desc ? n - 1 - i : i;
                    act.push_back(mk(1, 0, 0, 0, s + idx, 0, i));
                    act.push_back(mk(1, 0, 1, 0, d + idx, vals[i], i));
                end
            end else begin
                for (int i = 0; i < n; i++) act.push_back(mk(1, 0, 1, 0, d + i, f, i));
            end
        end
        aborted = abort_c >= 1 && abort_c <= act.size();
        if (aborted) while (act.size() > abort_c) void'(act.pop_back());
        words = 0;
        for (int k = 0; k < act.size(); k++) begin
            if (act[k].we) begin
                words++;
                if (rst_c == 0 || k + 1 < rst_c) exp_mem[int'(act[k].addr)] = act[k].wd;
            end
        end
        fin_err = fail || aborted;
        foreach (act[k]) q.push_back(act[k]);
        q.push_back(mk(0, 1, 0, fin_err, 0, 0, words));
        idle_err = fin_err;
        idle_words = words;
        total = act.size() + 1;

        first_we = -1;
        done_lat = 0;
        start = 1'b1; mode = m; src_addr = 32'(s); dst_addr = 32'(d); len = LEN_W'(n);
        fill_value = f;
        @(posedge clk); #1;
        if (spur) begin
            start = 1'b1; mode = $urandom_range(0, 1); src_addr = $urandom_range(0, 50);
            dst_addr = $urandom_range(0, 50); len = LEN_W'($urandom_range(1, 5));
            fill_value = $urandom;
        end else begin
            start = 1'b0;
        end
        for (int c = 1; c <= total; c++) begin
            if (c == rst_c) begin
                #1 rst_n = 1'b0;
                #1;
                chk("reset_we_comb", 64'(mem_we), 64'd0);
                chk("reset_busy", 64'(busy), 64'd0);
                chk("reset_addr", 64'(mem_addr), 64'd0);
                q.delete();
                idle_err = 1'b0;
                idle_words = 0;
                @(negedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                break;
            end
            if (done === 1'b1 && done_lat == 0) done_lat = c;
            abort = (c == abort_c);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[10 + i] = 32'hA5A5_0000 + 32'(i);
            exp_mem[10 + i] = mem[10 + i];
        end
        for (int i = 0; i < 5; i++) begin
            mem[i] = 32'(i + 1);
            exp_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Ascending copy, no overlap.
        run_cmd(0, 10, 100, 4, 0, 0, 0, 0);
        chk("copy_done_lat", 64'(done_lat), 64'd9);
        chk("copy_words", 64'(words_done), 64'd4);
        chk("copy_err", 64'(err), 64'd0);
        chk("copy_m100", 64'(mem[100]), 64'hA5A5_0000);
        chk("copy_m103", 64'(mem[103]), 64'hA5A5_0003);
        chk_mem("copy_mem");

        // Overlapping forward copy must run descending.
        run_cmd(0, 0, 2, 5, 0, 0, 0, 0);
        chk("ovl_first_write", 64'(first_we), 64'd6);
        chk("ovl_done_lat", 64'(done_lat), 64'd11);
        for (int i = 0; i < 5; i++) chk("ovl_value", 64'(mem[2 + i]), 64'(i + 1));
        chk_mem("ovl_mem");

        // Fill.
        saved = mem[53];
        run_cmd(1, 0, 50, 3, 32'hDEAD_BEEF, 0, 0, 0);
        chk("fill_done_lat", 64'(done_lat), 64'd4);
        chk("fill_m50", 64'(mem[50]), 64'hDEAD_BEEF);
        chk("fill_m52", 64'(mem[52]), 64'hDEAD_BEEF);
        chk("fill_m53", 64'(mem[53]), 64'(saved));

        // Range errors.
        run_cmd(1, 0, 3998, 3, 32'h1234_5678, 0, 0, 0);
        chk("rng_dst_done_lat", 64'(done_lat), 64'd1);
        chk("rng_dst_err", 64'(err), 64'd1);
        chk("rng_dst_words", 64'(words_done), 64'd0);
        chk("rng_dst_no_we", 64'(first_we), 64'hFFFF_FFFF_FFFF_FFFF);
        run_cmd(0, 3999, 0, 2, 0, 0, 0, 0);
        chk("rng_src_done_lat", 64'(done_lat), 64'd1);
        chk("rng_src_err", 64'(err), 64'd1);
        chk("rng_src_no_we", 64'(first_we), 64'hFFFF_FFFF_FFFF_FFFF);

        // Abort at the edge ending the 3rd WR, with start held while busy.
        run_cmd(0, 200, 300, 8, 0, 6, 0, 1);
        chk("abort_words", 64'(words_done), 64'd3);
        chk("abort_err", 64'(err), 64'd1);
        chk("abort_done_lat", 64'(done_lat), 64'd7);
        chk_mem("abort_mem");

        // Reset during the 3rd FILL cycle: two writes landed, then all outputs cleared.
        saved = mem[402];
        run_cmd(1, 0, 400, 6, 32'hCAFE_F00D, 0, 3, 0);
        chk("rst_m401", 64'(mem[401]), 64'hCAFE_F00D);
        chk("rst_m402", 64'(mem[402]), 64'(saved));
        chk("rst_words", 64'(words_done), 64'd0);
        run_cmd(0, 500, 520, 3, 0, 0, 0, 0);
        chk("post_rst_words", 64'(words_done), 64'd3);
        run_cmd(0, 7, 9, 0, 0, 0, 0, 0);
        chk("len0_done_lat", 64'(done_lat), 64'd1);
        chk("len0_err", 64'(err), 64'd0);
        chk_mem("directed_mem");

        for (int t = 0; t < 40; t++) begin
            int s, d, n, ab;
            logic m;
            m = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 9) == 0) s = $urandom_range(3985, 3999);
            else s = $urandom_range(0, 60);
            if ($urandom_range(0, 9) == 0) d = $urandom_range(3985, 3999);
            else d = $urandom_range(0, 60);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n + 1) : 0;
            run_cmd(m, s, d, n, $urandom, ab, 0, 1'($urandom_range(0, 1)));
            chk_mem("rand_mem");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-master block driving the single-port data memory (combinational read, synchronous write on `WE`) to block-copy or block-fill words without CPU involvement. It sits beside the CPU's load/store path on the data-memory port and is started by a one-cycle command. It sequences memory reads and writes through a small FSM and reports completion, progress and errors. Port-sharing arbitration is external to this block.

## Interface
- `DEPTH`, 4000: number of words in the target memory; addresses are word indices `0..DEPTH-1`.
- `LEN_W`, 16: width of the length and progress counters.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `mode` in 1: 0 = copy, 1 = fill.
- `src_addr` in 32: copy source base, word index.
- `dst_addr` in 32: destination base, word index.
- `len` in LEN_W: number of words.
- `fill_value` in 32: pattern written in fill mode.
- `abort` in 1: stop the transfer early.
- `busy` out 1: high in RD, WR and FILL.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: range error or abort on the last command.
- `words_done` out LEN_W: count of words written by the last command.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory read data, combinational from `mem_addr`.

## Operation
- States: IDLE, RD, WR, FILL, FIN.
- IDLE + `start`: latch `mode`, `len`, `fill_value` and the computed cursors; clear `words_done` and `err`.
  - Range check uses 33-bit arithmetic. Fail if `dst_addr+len > DEPTH`, or if copy mode and `src_addr+len > DEPTH`.
  - On failure: go to FIN with `err`=1; no memory write occurs.
  - `len`=0: go to FIN with `err`=0.
  - Otherwise: copy mode goes to RD, fill mode goes to FILL.
- Copy direction:
  - If `dst_addr > src_addr`: descending. Cursors start at `src+len-1` / `dst+len-1` and decrement. This gives memmove-correct results for overlapping ranges.
  - Otherwise: ascending from the bases.
- RD: `mem_we`=0, `mem_addr`=src cursor. At the edge, capture `mem_rd` into the buffer, then go to WR.
- WR:
  - Drive `mem_we`=1, `mem_addr`=dst cursor, `mem_wd`=buffer.
  - At the edge: increment `words_done`, step both cursors.
  - If this was the last word, go to FIN; else go to RD.
- FILL:
  - Drive `mem_we`=1, `mem_addr`=dst cursor (ascending), `mem_wd`=`fill_value`.
  - Each edge: increment `words_done`; go to FIN after the last word.
- `abort` is sampled at edges in RD, WR and FILL.
  - A WR/FILL write in that cycle still commits and is counted.
  - Next state is FIN with `err`=1.
  - Abort sampled in RD discards the buffered word.
- FIN: `done`=1 for one cycle, then IDLE.
- `err` and `words_done` hold until the next accepted `start`.
- `start` is ignored outside IDLE.
- Outside RD, WR and FILL, `mem_we`, `mem_addr` and `mem_wd` are 0.

## Timing
- Reset: state IDLE. `busy`, `done`, `err`, `words_done`, `mem_we`, `mem_addr`, `mem_wd` and all internal registers are 0.
  - Reset mid-transfer forces `mem_we`=0 immediately, so no write occurs in the reset cycle.
- `start` accepted at edge E0. First RD/FILL cycle is E0→E1.
- Copy of N words: 2N cycles of memory activity; `done` is high in cycle 2N+1 after E0.
- Fill of N words: N cycles; `done` is high in cycle N+1.
- Range error or `len`=0: `done` is high in cycle 1 after E0.
- `busy` falls in the FIN cycle.
- A new `start` can be accepted in the cycle after FIN.
- `mem_rd` must settle within the RD cycle; it is never registered externally.

## Test plan
- Copy ascending, no overlap: preload mem[10..13]=A,B,C,D; copy src=10, dst=100, len=4 → mem[100..103]=A,B,C,D, `done` 9 cycles after start, `words_done`=4, `err`=0.
- Overlapping forward copy: mem[0..4]=1..5; copy src=0, dst=2, len=5 → mem[2..6]=1,2,3,4,5 (descending order; first write to address 6).
- Fill: dst=50, len=3, `fill_value`=0xDEADBEEF → mem[50..52]=0xDEADBEEF, mem[53] unchanged, `done` 4 cycles after start.
- Range error: dst=3998, len=3 → no `mem_we` pulse, `done` 1 cycle after start, `err`=1, `words_done`=0; same outcome with src=3999, len=2 in copy mode.
- Abort: copy len=8, assert `abort` at the edge ending the 3rd WR → exactly 3 words written, `err`=1, `words_done`=3; `start` while busy is ignored.
- Reset mid-fill (`rst_n` low during a FILL cycle) → `mem_we` drops combinationally, all outputs 0; a new command completes normally after release; `len`=0 gives `done` with `err`=0.
